// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a single UART transmitter.
// The grant is locked per packet, owners rotate round-robin, and an optional burst
// cap hands the transmitter to a waiting requester. Per-requester byte counters are kept.
module uart_tx_arbiter #(
   parameter int MAX_BURST   = 16,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic [7:0]             AData,
   input  logic                   AValid,
   input  logic                   ALast,
   output logic                   AReady,
   input  logic [7:0]             BData,
   input  logic                   BValid,
   input  logic                   BLast,
   output logic                   BReady,
   output logic [7:0]             DataIn,
   output logic                   DataInValid,
   input  logic                   DataInReady,
   output logic [1:0]             Grant,
   output logic [COUNT_WIDTH-1:0] ACount,
   output logic [COUNT_WIDTH-1:0] BCount
);

   localparam int                 BURST_W   = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
   localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(MAX_BURST);

   typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} state_t;

   typedef struct packed {
      logic [7:0] data;
      logic       valid;
      logic       last;
   } req_t;

   state_t                          state, nextState;
   req_t [1:0]                      reqs;
   req_t                            cur;
   logic                            lastOwner;   // 0 = A, 1 = B
   logic                            ownSel;
   logic                            owned;
   logic                            otherValid;
   logic                            xfer;
   logic                            capHit;
   logic                            releaseGrant;
   logic [BURST_W-1:0]              burst, burstNext;
   logic [1:0][COUNT_WIDTH-1:0]     cnt;

   assign reqs[0] = '{data: AData, valid: AValid, last: ALast};
   assign reqs[1] = '{data: BData, valid: BValid, last: BLast};

   assign owned      = (state != IDLE);
   assign ownSel     = (state == OWN_B);
   assign cur        = reqs[ownSel];
   assign otherValid = ownSel ? AValid : BValid;

   // A transfer is the owner's valid meeting the UART's ready
   assign xfer      = owned & cur.valid & DataInReady;
   assign burstNext = (burst == BURST_CAP) ? burst : burst + 1'b1;
   // Once saturated, burstNext stays at the cap, so each later transfer re-checks the waiter
   assign capHit       = (MAX_BURST != 0) && (burstNext == BURST_CAP) && otherValid;
   assign releaseGrant = xfer & (cur.last | capHit);

   // State register
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= nextState;
   end

   // Next-state: round-robin pick from IDLE, release on Last or burst-cap preemption
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (AValid && BValid) nextState = lastOwner ? OWN_A : OWN_B;
            else if (AValid)      nextState = OWN_A;
            else if (BValid)      nextState = OWN_B;
         end
         OWN_A, OWN_B: if (releaseGrant) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Outputs: combinational pass-through of the owner's stream, zeros when idle
   always_comb begin
      Grant       = {state == OWN_B, state == OWN_A};
      DataIn      = 8'h00;
      DataInValid = 1'b0;
      AReady      = (state == OWN_A) & DataInReady;
      BReady      = (state == OWN_B) & DataInReady;
      if (owned) begin
         DataIn      = cur.data;
         DataInValid = cur.valid;
      end
   end

   // Most recent owner, seeded with B so A wins the first tie
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)            lastOwner <= 1'b1;
      else if (releaseGrant) lastOwner <= ownSel;
   end

   // Burst count is held at zero while idle, which clears it on every new grant
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)     burst <= '0;
      else if (!owned) burst <= '0;
      else if (xfer)   burst <= burstNext;
   end

   for (genvar i = 0; i < 2; i++) begin : gCnt
      // Byte counter for requester i, wraps silently
      always_ff @(posedge Clock or negedge Reset) begin
         if (!Reset)                          cnt[i] <= '0;
         else if (xfer && (ownSel == 1'(i))) cnt[i] <= cnt[i] + 1'b1;
      end
   end

   assign ACount = cnt[0];
   assign BCount = cnt[1];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester drivers push expected bytes into per-requester
// queues; a UART-side monitor pops and compares every byte the transmitter accepts.
module tb_uart_tx_arbiter;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [7:0]  AData, BData;
   logic        AValid, ALast, BValid, BLast;
   logic        AReady, BReady;
   logic [7:0]  DataIn;
   logic        DataInValid;
   logic        DataInReady;
   logic [1:0]  Grant;
   logic [15:0] ACount, BCount;

   int          nChecks = 0;
   int          nFail   = 0;
   int          xferCnt = 0;
   bit          logEn   = 0;
   logic [7:0]  qA[$], qB[$];
   logic [1:0]  gLog[$];
   string       oStr = "";

   uart_tx_arbiter #(.MAX_BURST(16), .COUNT_WIDTH(16)) dut (
      .Clock(Clock), .Reset(Reset),
      .AData(AData), .AValid(AValid), .ALast(ALast), .AReady(AReady),
      .BData(BData), .BValid(BValid), .BLast(BLast), .BReady(BReady),
      .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
      .Grant(Grant), .ACount(ACount), .BCount(BCount)
   );

   always #5 Clock = ~Clock;

   // UART-side monitor / scoreboard
   initial begin
      logic [7:0] exp;
      forever begin
         @(negedge Clock);
         if (logEn) gLog.push_back(Grant);
         if (Reset && DataInValid && DataInReady) begin
            xferCnt++;
            nChecks++;
            if (Grant == 2'b01 && qA.size() > 0) begin
               exp = qA.pop_front();
               oStr = {oStr, "A"};
               if (DataIn !== exp) begin
                  nFail++;
                  $display("FAIL byteA: got %h expected %h", DataIn, exp);
               end
            end else if (Grant == 2'b10 && qB.size() > 0) begin
               exp = qB.pop_front();
               oStr = {oStr, "B"};
               if (DataIn !== exp) begin
                  nFail++;
                  $display("FAIL byteB: got %h expected %h", DataIn, exp);
               end
            end else begin
               nFail++;
               $display("FAIL unexpectedByte: got %h grant %b qA=%0d qB=%0d", DataIn, Grant, qA.size(), qB.size());
            end
         end
      end
   end

   function automatic string grantRuns();
      string s = "";
      for (int i = 0; i < gLog.size(); i++)
         if (i == 0 || gLog[i] != gLog[i-1]) s = {s, $sformatf("%0d", gLog[i])};
      return s;
   endfunction

   task automatic setReq(input bit isB, input logic v, input logic [7:0] d, input logic l);
      if (isB) begin BValid = v; BData = d; BLast = l; end
      else     begin AValid = v; AData = d; ALast = l; end
   endtask

   // Drives one packet; optional valid drop before byte dropAt, optional early return
   task automatic sendPkt(input bit isB, input logic [7:0] d[$], input int dropAt,
                          input int dropLen, input int stopAfter);
      bit acc;
      int n = d.size();
      for (int i = 0; i < n; i++) begin
         if (isB) qB.push_back(d[i]); else qA.push_back(d[i]);
      end
      for (int i = 0; i < n; i++) begin
         if (i == dropAt) begin
            setReq(isB, 1'b0, 8'h00, 1'b0);
            repeat (dropLen) begin
               @(negedge Clock);
               nChecks++;
               if (DataInValid !== 1'b0 || Grant !== 2'b01) begin
                  nFail++;
                  $display("FAIL dropValid: DataInValid %b Grant %b expected 0 01", DataInValid, Grant);
               end
               @(posedge Clock); #1;
            end
         end
         setReq(isB, 1'b1, d[i], (i == n-1));
         acc = 0;
         for (int c = 0; c < 500 && !acc; c++) begin
            @(negedge Clock);
            acc = isB ? BReady : AReady;
            @(posedge Clock); #1;
         end
         if (!acc) begin
            nChecks++; nFail++;
            $display("FAIL timeout: requester %0d byte %0d not accepted, expected accept within 500 cycles", isB, i);
            setReq(isB, 1'b0, 8'h00, 1'b0);
            return;
         end
         if (i + 1 == stopAfter) return;
      end
      setReq(isB, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic doReset();
      logEn = 0;
      Reset = 1'b0;
      setReq(0, 1'b0, 8'h00, 1'b0);
      setReq(1, 1'b0, 8'h00, 1'b0);
      DataInReady = 1'b1;
      repeat (2) @(posedge Clock);
      #3 Reset = 1'b1;
      @(posedge Clock); #1;
      qA.delete(); qB.delete(); gLog.delete();
      oStr = ""; xferCnt = 0; logEn = 1;
   endtask

   task automatic checkEnd(input string name, input string expRuns, input int expA, input int expB);
      repeat (2) @(negedge Clock);
      nChecks++;
      if (grantRuns() != expRuns) begin
         nFail++; $display("FAIL %s grantSeq: got %s expected %s", name, grantRuns(), expRuns);
      end
      nChecks++;
      if (ACount !== 16'(expA) || BCount !== 16'(expB)) begin
         nFail++; $display("FAIL %s counts: got A=%0d B=%0d expected A=%0d B=%0d", name, ACount, BCount, expA, expB);
      end
      nChecks++;
      if (qA.size() != 0 || qB.size() != 0) begin
         nFail++; $display("FAIL %s leftover: got qA=%0d qB=%0d expected 0 0", name, qA.size(), qB.size());
      end
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      setReq(0, 1'b1, 8'h55, 1'b0);
      setReq(1, 1'b1, 8'hAA, 1'b0);
      DataInReady = 1'b1;
      repeat (2) @(posedge Clock);
      #2;
      nChecks++;
      if (Grant !== 2'b00 || DataInValid !== 1'b0 || DataIn !== 8'h00 || AReady !== 1'b0 ||
          BReady !== 1'b0 || ACount !== 16'd0 || BCount !== 16'd0) begin
         nFail++;
         $display("FAIL resetState: got G=%b V=%b D=%h AR=%b BR=%b AC=%0d BC=%0d expected all zero",
                  Grant, DataInValid, DataIn, AReady, BReady, ACount, BCount);
      end
      doReset();
      @(negedge Clock);
      nChecks++;
      if (AReady !== 1'b0 || BReady !== 1'b0 || Grant !== 2'b00) begin
         nFail++; $display("FAIL idleReady: got AR=%b BR=%b G=%b expected 0 0 00", AReady, BReady, Grant);
      end
      @(posedge Clock); #1;
   endtask

   task automatic test_single();
      logic [7:0] d[$] = '{8'h48, 8'h69, 8'h0A};
      doReset();
      fork
         sendPkt(0, d, -1, 0, 0);
         begin
            @(negedge Clock);
            nChecks++;
            if (Grant !== 2'b00) begin
               nFail++; $display("FAIL latencyIdle: got %b expected 00", Grant);
            end
            @(negedge Clock);
            nChecks++;
            if (Grant !== 2'b01) begin
               nFail++; $display("FAIL latencyGrant: got %b expected 01", Grant);
            end
         end
      join
      checkEnd("single", "010", 3, 0);
   endtask

   task automatic test_back_to_back();
      logic [7:0] da[$] = '{8'hA1, 8'hA2};
      logic [7:0] db[$] = '{8'hB1, 8'hB2};
      int lastA, firstB;
      doReset();
      fork
         sendPkt(0, da, -1, 0, 0);
         sendPkt(1, db, -1, 0, 0);
      join
      checkEnd("b2b", "01020", 2, 2);
      nChecks++;
      if (oStr != "AABB") begin
         nFail++; $display("FAIL b2bOrder: got %s expected AABB", oStr);
      end
      lastA = -1; firstB = -1;
      for (int i = 0; i < gLog.size(); i++) begin
         if (gLog[i] == 2'b01) lastA = i;
         if (gLog[i] == 2'b10 && firstB < 0) firstB = i;
      end
      nChecks++;
      if (firstB - lastA != 2) begin
         nFail++; $display("FAIL b2bIdleGap: got %0d idle cycles expected 1", firstB - lastA - 1);
      end
   endtask

   task automatic test_burst_cap();
      logic [7:0] da[$];
      logic [7:0] db[$] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
      string exp = "";
      for (int i = 0; i < 40; i++) da.push_back(8'(i + 1));
      for (int i = 0; i < 16; i++) exp = {exp, "A"};
      for (int i = 0; i < 4; i++)  exp = {exp, "B"};
      for (int i = 0; i < 24; i++) exp = {exp, "A"};
      doReset();
      fork
         sendPkt(0, da, -1, 0, 0);
         begin
            repeat (2) @(posedge Clock); #1;
            sendPkt(1, db, -1, 0, 0);
         end
      join
      checkEnd("cap", "0102010", 40, 4);
      nChecks++;
      if (oStr != exp) begin
         nFail++; $display("FAIL capOrder: got %s expected %s", oStr, exp);
      end
   endtask

   task automatic test_no_contention();
      logic [7:0] da[$];
      for (int i = 0; i < 40; i++) da.push_back(8'(8'h80 + i));
      doReset();
      sendPkt(0, da, -1, 0, 0);
      checkEnd("noCont", "010", 40, 0);
   endtask

   task automatic test_stalls();
      logic [7:0] da[$];
      bit ok;
      for (int i = 0; i < 10; i++) da.push_back(8'(8'h30 + i));
      doReset();
      fork
         sendPkt(0, da, -1, 0, 0);
         begin
            for (int c = 0; c < 1000 && xferCnt < 3; c++) @(posedge Clock);
            #1 DataInReady = 1'b0;
            ok = 1;
            repeat (50) begin
               @(negedge Clock);
               if (Grant !== 2'b01 || AReady !== 1'b0) ok = 0;
            end
            @(posedge Clock); #1 DataInReady = 1'b1;
            nChecks++;
            if (!ok) begin
               nFail++; $display("FAIL readyStall: grant or AReady wrong during stall, expected 01 and 0");
            end
         end
      join
      checkEnd("readyLow", "010", 10, 0);
      doReset();
      sendPkt(0, da, 4, 5, 0);
      checkEnd("validDrop", "010", 10, 0);
   endtask

   task automatic test_reset_mid_packet();
      logic [7:0] da[$] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      logic [7:0] df[$] = '{8'h11, 8'h22};
      doReset();
      sendPkt(0, da, -1, 0, 2);
      nChecks++;
      if (ACount !== 16'd2) begin
         nFail++; $display("FAIL preAbortCount: got %0d expected 2", ACount);
      end
      #2 Reset = 1'b0;
      #1;
      nChecks++;
      if (Grant !== 2'b00 || DataInValid !== 1'b0 || ACount !== 16'd0 || BCount !== 16'd0 || AReady !== 1'b0) begin
         nFail++;
         $display("FAIL abortState: got G=%b V=%b AC=%0d BC=%0d AR=%b expected 00 0 0 0 0",
                  Grant, DataInValid, ACount, BCount, AReady);
      end
      setReq(0, 1'b0, 8'h00, 1'b0);
      qA.delete();
      @(posedge Clock);
      #3 Reset = 1'b1;
      @(posedge Clock); #1;
      gLog.delete();
      sendPkt(0, df, -1, 0, 0);
      checkEnd("afterAbort", "010", 2, 0);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_burst_cap();
      test_no_contention();
      test_stalls();
      test_reset_mid_packet();
      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
